// File: rtl/alu_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit_pkg
//  Purpose  : Shared widths, RV32I opcode / funct3 encodings and the branch
//             condition helper used by the ALU execution unit.
//  Revision : 1.0  initial release
// ============================================================================
package alu_exec_unit_pkg;

  // Default widths, matching the reservation station side of the interface
  localparam int ROB_POS_W_DEF = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 32;

  // Shift amount is always the low five bits of the second operand
  localparam int SHAMT_W = 5;

  // RV32I major opcodes handled by this unit
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;

  // funct3 encodings for OP / OP-IMM
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct3 encodings for BRANCH
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Branch decision from precomputed compare flags; reserved funct3 values
  // (010, 011) resolve as not taken.
  function automatic logic branch_taken(
    input logic [2:0] funct3,
    input logic       eq,
    input logic       lt_s,
    input logic       lt_u
  );
    logic taken;
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = ~lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = ~lt_u;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Purpose  : Purely combinational RV32I integer / branch / jump evaluation.
//             Takes the E1-registered operands and produces the rd value,
//             the control-transfer flag and the next PC.
//  Revision : 1.0  initial release
// ============================================================================
module alu_core
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic              funct7_i,
  input  logic [DATA_W-1:0] val1_i,
  input  logic [DATA_W-1:0] val2_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [DATA_W-1:0] val_o,
  output logic              jump_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0]  w_pc_plus4;
  logic [ADDR_W-1:0]  w_pc_plus_imm;
  logic [ADDR_W-1:0]  w_jalr_tgt;
  logic [DATA_W-1:0]  w_jalr_sum;
  logic [DATA_W-1:0]  w_op2;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_is_sub;
  logic               w_op2_lt_s;
  logic               w_op2_lt_u;
  logic               w_br_eq;
  logic               w_br_lt_s;
  logic               w_br_lt_u;
  logic               w_br_taken;
  logic [DATA_W-1:0]  w_alu_val;

  // Address arithmetic shared by jumps, branches and the fall-through path
  always_comb begin
    w_pc_plus4    = pc_i + ADDR_W'(4);
    w_pc_plus_imm = pc_i + ADDR_W'(imm_i);
    w_jalr_sum    = val1_i + imm_i;
    // JALR clears the LSB of the computed target
    w_jalr_tgt    = ADDR_W'(w_jalr_sum) & ~ADDR_W'(1);
  end

  // Operand selection and compare flags for OP/OP-IMM and BRANCH
  always_comb begin
    // OP uses rs2; OP-IMM (and anything else) uses the immediate
    w_op2      = (opcode_i == OP_OP) ? val2_i : imm_i;
    w_shamt    = w_op2[SHAMT_W-1:0];
    // SUB exists only in the register form; ADDI ignores bit 30
    w_is_sub   = (opcode_i == OP_OP) && funct7_i;
    w_op2_lt_s = $signed(val1_i) < $signed(w_op2);
    w_op2_lt_u = val1_i < w_op2;
    w_br_eq    = (val1_i == val2_i);
    w_br_lt_s  = $signed(val1_i) < $signed(val2_i);
    w_br_lt_u  = val1_i < val2_i;
    w_br_taken = branch_taken(funct3_i, w_br_eq, w_br_lt_s, w_br_lt_u);
  end

  // Integer ALU result for OP / OP-IMM
  always_comb begin
    w_alu_val = '0;
    case (funct3_i)
      F3_ADD_SUB: w_alu_val = w_is_sub ? (val1_i - w_op2) : (val1_i + w_op2);
      F3_SLL:     w_alu_val = val1_i << w_shamt;
      F3_SLT:     w_alu_val = {{(DATA_W-1){1'b0}}, w_op2_lt_s};
      F3_SLTU:    w_alu_val = {{(DATA_W-1){1'b0}}, w_op2_lt_u};
      F3_XOR:     w_alu_val = val1_i ^ w_op2;
      // Bit 30 selects arithmetic shift for both SRA and SRAI
      F3_SRL_SRA: w_alu_val = funct7_i ? DATA_W'($signed(val1_i) >>> w_shamt)
                                       : (val1_i >> w_shamt);
      F3_OR:      w_alu_val = val1_i | w_op2;
      F3_AND:     w_alu_val = val1_i & w_op2;
      default:    w_alu_val = '0;
    endcase
  end

  // Per-opcode selection of rd value, jump flag and next PC
  always_comb begin
    val_o  = '0;
    jump_o = 1'b0;
    pc_o   = w_pc_plus4;
    case (opcode_i)
      OP_LUI: begin
        val_o = imm_i;
      end
      OP_AUIPC: begin
        val_o = DATA_W'(w_pc_plus_imm);
      end
      OP_JAL: begin
        val_o  = DATA_W'(w_pc_plus4);
        jump_o = 1'b1;
        pc_o   = w_pc_plus_imm;
      end
      OP_JALR: begin
        val_o  = DATA_W'(w_pc_plus4);
        jump_o = 1'b1;
        pc_o   = w_jalr_tgt;
      end
      OP_BRANCH: begin
        val_o  = '0;
        jump_o = w_br_taken;
        pc_o   = w_br_taken ? w_pc_plus_imm : w_pc_plus4;
      end
      OP_OP, OP_OP_IMM: begin
        val_o = w_alu_val;
      end
      default: begin
        // Unknown opcodes still broadcast, with a zero value and fall-through
        val_o = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : Two-stage RV32I ALU execution unit behind the reservation
//             station dispatch port. E1 captures the dispatched op, E2
//             evaluates it and registers the result broadcast for the
//             RS / LSB / ROB plus the jump information for the ROB.
//  Revision : 1.0  initial release
// ============================================================================
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int ROB_POS_W = ROB_POS_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 alu_en,
  input  logic [6:0]           alu_opcode,
  input  logic [2:0]           alu_funct3,
  input  logic                 alu_funct7,
  input  logic [DATA_W-1:0]    alu_val1,
  input  logic [DATA_W-1:0]    alu_val2,
  input  logic [DATA_W-1:0]    alu_imm,
  input  logic [ADDR_W-1:0]    alu_pc,
  input  logic [ROB_POS_W-1:0] alu_rob_pos,
  output logic                 alu_result,
  output logic [ROB_POS_W-1:0] alu_result_rob_pos,
  output logic [DATA_W-1:0]    alu_result_val,
  output logic                 alu_result_jump,
  output logic [ADDR_W-1:0]    alu_result_pc
);

  // E1 pipeline registers
  logic                 e1_valid_q,   e1_valid_d;
  logic [6:0]           e1_opcode_q,  e1_opcode_d;
  logic [2:0]           e1_funct3_q,  e1_funct3_d;
  logic                 e1_funct7_q,  e1_funct7_d;
  logic [DATA_W-1:0]    e1_val1_q,    e1_val1_d;
  logic [DATA_W-1:0]    e1_val2_q,    e1_val2_d;
  logic [DATA_W-1:0]    e1_imm_q,     e1_imm_d;
  logic [ADDR_W-1:0]    e1_pc_q,      e1_pc_d;
  logic [ROB_POS_W-1:0] e1_rob_pos_q, e1_rob_pos_d;

  // E2 (output) registers
  logic                 res_valid_q,   res_valid_d;
  logic [ROB_POS_W-1:0] res_rob_pos_q, res_rob_pos_d;
  logic [DATA_W-1:0]    res_val_q,     res_val_d;
  logic                 res_jump_q,    res_jump_d;
  logic [ADDR_W-1:0]    res_pc_q,      res_pc_d;

  // Combinational evaluation of the op held in E1
  logic [DATA_W-1:0]    w_core_val;
  logic                 w_core_jump;
  logic [ADDR_W-1:0]    w_core_pc;

  alu_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_alu_core (
    .opcode_i (e1_opcode_q),
    .funct3_i (e1_funct3_q),
    .funct7_i (e1_funct7_q),
    .val1_i   (e1_val1_q),
    .val2_i   (e1_val2_q),
    .imm_i    (e1_imm_q),
    .pc_i     (e1_pc_q),
    .val_o    (w_core_val),
    .jump_o   (w_core_jump),
    .pc_o     (w_core_pc)
  );

  // Next-state: freeze on !rdy, flush valids on rollback, else advance
  always_comb begin
    e1_valid_d    = e1_valid_q;
    e1_opcode_d   = e1_opcode_q;
    e1_funct3_d   = e1_funct3_q;
    e1_funct7_d   = e1_funct7_q;
    e1_val1_d     = e1_val1_q;
    e1_val2_d     = e1_val2_q;
    e1_imm_d      = e1_imm_q;
    e1_pc_d       = e1_pc_q;
    e1_rob_pos_d  = e1_rob_pos_q;
    res_valid_d   = res_valid_q;
    res_rob_pos_d = res_rob_pos_q;
    res_val_d     = res_val_q;
    res_jump_d    = res_jump_q;
    res_pc_d      = res_pc_q;

    if (rdy) begin
      if (rollback) begin
        // Drop the op being dispatched and everything in flight
        e1_valid_d  = 1'b0;
        res_valid_d = 1'b0;
      end else begin
        e1_valid_d   = alu_en;
        e1_opcode_d  = alu_opcode;
        e1_funct3_d  = alu_funct3;
        e1_funct7_d  = alu_funct7;
        e1_val1_d    = alu_val1;
        e1_val2_d    = alu_val2;
        e1_imm_d     = alu_imm;
        e1_pc_d      = alu_pc;
        e1_rob_pos_d = alu_rob_pos;

        res_valid_d = e1_valid_q;
        // Payload only moves with a valid op so idle cycles hold it stable
        if (e1_valid_q) begin
          res_rob_pos_d = e1_rob_pos_q;
          res_val_d     = w_core_val;
          res_jump_d    = w_core_jump;
          res_pc_d      = w_core_pc;
        end
      end
    end
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      e1_valid_q    <= 1'b0;
      e1_opcode_q   <= '0;
      e1_funct3_q   <= '0;
      e1_funct7_q   <= 1'b0;
      e1_val1_q     <= '0;
      e1_val2_q     <= '0;
      e1_imm_q      <= '0;
      e1_pc_q       <= '0;
      e1_rob_pos_q  <= '0;
      res_valid_q   <= 1'b0;
      res_rob_pos_q <= '0;
      res_val_q     <= '0;
      res_jump_q    <= 1'b0;
      res_pc_q      <= '0;
    end else begin
      e1_valid_q    <= e1_valid_d;
      e1_opcode_q   <= e1_opcode_d;
      e1_funct3_q   <= e1_funct3_d;
      e1_funct7_q   <= e1_funct7_d;
      e1_val1_q     <= e1_val1_d;
      e1_val2_q     <= e1_val2_d;
      e1_imm_q      <= e1_imm_d;
      e1_pc_q       <= e1_pc_d;
      e1_rob_pos_q  <= e1_rob_pos_d;
      res_valid_q   <= res_valid_d;
      res_rob_pos_q <= res_rob_pos_d;
      res_val_q     <= res_val_d;
      res_jump_q    <= res_jump_d;
      res_pc_q      <= res_pc_d;
    end
  end

  assign alu_result         = res_valid_q;
  assign alu_result_rob_pos = res_rob_pos_q;
  assign alu_result_val     = res_val_q;
  assign alu_result_jump    = res_jump_q;
  assign alu_result_pc      = res_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Purpose  : Scoreboard testbench for alu_exec_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_unit;

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] val;
    logic        jump;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, alu_en;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;
  logic        alu_result;
  logic [3:0]  alu_result_rob_pos;
  logic [31:0] alu_result_val;
  logic        alu_result_jump;
  logic [31:0] alu_result_pc;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  logic edge_rdy = 1'b0;
  logic edge_rst = 1'b1;

  alu_exec_unit dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .rollback           (rollback),
    .alu_en             (alu_en),
    .alu_opcode         (alu_opcode),
    .alu_funct3         (alu_funct3),
    .alu_funct7         (alu_funct7),
    .alu_val1           (alu_val1),
    .alu_val2           (alu_val2),
    .alu_imm            (alu_imm),
    .alu_pc             (alu_pc),
    .alu_rob_pos        (alu_rob_pos),
    .alu_result         (alu_result),
    .alu_result_rob_pos (alu_result_rob_pos),
    .alu_result_val     (alu_result_val),
    .alu_result_jump    (alu_result_jump),
    .alu_result_pc      (alu_result_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference behaviour of one op
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] v1, input logic [31:0] v2,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [3:0] rob);
    exp_t        e;
    logic [31:0] b;
    logic        t;
    e.rob = rob; e.val = 32'd0; e.jump = 1'b0; e.pc = pc + 32'd4;
    t = 1'b0;
    b = (op == 7'b0110011) ? v2 : imm;
    case (op)
      7'b0110111: e.val = imm;
      7'b0010111: e.val = pc + imm;
      7'b1101111: begin e.val = pc + 32'd4; e.jump = 1'b1; e.pc = pc + imm; end
      7'b1100111: begin e.val = pc + 32'd4; e.jump = 1'b1; e.pc = (v1 + imm) & 32'hFFFF_FFFE; end
      7'b1100011: begin
        case (f3)
          3'd0: t = (v1 == v2);
          3'd1: t = (v1 != v2);
          3'd4: t = ($signed(v1) <  $signed(v2));
          3'd5: t = ($signed(v1) >= $signed(v2));
          3'd6: t = (v1 <  v2);
          3'd7: t = (v1 >= v2);
          default: t = 1'b0;
        endcase
        e.jump = t;
        if (t) e.pc = pc + imm;
      end
      7'b0110011, 7'b0010011: begin
        case (f3)
          3'd0: e.val = (op == 7'b0110011 && f7) ? v1 - b : v1 + b;
          3'd1: e.val = v1 << b[4:0];
          3'd2: e.val = ($signed(v1) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: e.val = (v1 < b) ? 32'd1 : 32'd0;
          3'd4: e.val = v1 ^ b;
          3'd5: e.val = f7 ? 32'($signed(v1) >>> b[4:0]) : v1 >> b[4:0];
          3'd6: e.val = v1 | b;
          default: e.val = v1 & b;
        endcase
      end
      default: e.val = 32'd0;
    endcase
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
    alu_en = 1'b1; alu_opcode = op; alu_funct3 = f3; alu_funct7 = f7;
    alu_val1 = v1; alu_val2 = v2; alu_imm = imm; alu_pc = pc; alu_rob_pos = rob;
  endtask

  task automatic push(input logic [3:0] rob, input logic [31:0] val, input logic jump,
                      input logic [31:0] pc);
    exp_t e;
    e.rob = rob; e.val = val; e.jump = jump; e.pc = pc;
    sb_q.push_back(e);
  endtask

  // Directed single op with spec-given expectations, then drain
  task automatic one(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                     input logic [31:0] pc, input logic [3:0] rob,
                     input logic [31:0] ev, input logic ej, input logic [31:0] epc);
    drive(op, f3, f7, v1, v2, imm, pc, rob);
    push(rob, ev, ej, epc);
    cyc();
    alu_en = 1'b0;
    cyc();
    cyc();
  endtask

  // Track whether the last edge was allowed to update the DUT
  always @(posedge clk) begin
    edge_rdy <= rdy;
    edge_rst <= rst;
  end

  // Scoreboard: each fresh broadcast pulse retires the oldest expectation
  always @(negedge clk) begin
    if (alu_result && edge_rdy && !edge_rst) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rob_pos", 64'(alu_result_rob_pos), 64'(e.rob));
        chk("val",     64'(alu_result_val),     64'(e.val));
        chk("jump",    64'(alu_result_jump),    64'(e.jump));
        chk("pc_out",  64'(alu_result_pc),      64'(e.pc));
      end
    end
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; alu_en = 1'b0;
    alu_opcode = '0; alu_funct3 = '0; alu_funct7 = 1'b0;
    alu_val1 = '0; alu_val2 = '0; alu_imm = '0; alu_pc = '0; alu_rob_pos = '0;
    cyc();
    cyc();
    chk("rst_result",  64'(alu_result), 64'd0);
    chk("rst_rob_pos", 64'(alu_result_rob_pos), 64'd0);
    chk("rst_val",     64'(alu_result_val), 64'd0);
    chk("rst_jump",    64'(alu_result_jump), 64'd0);
    chk("rst_pc",      64'(alu_result_pc), 64'd0);
    rst = 1'b0;
    cyc();

    // ADD with explicit latency checks
    drive(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 32'h40, 4'd3);
    push(4'd3, 32'd12, 1'b0, 32'h44);
    cyc();
    alu_en = 1'b0;
    chk("add_lat_e0", 64'(alu_result), 64'd0);
    cyc();
    chk("add_lat_e1", 64'(alu_result), 64'd1);
    cyc();
    chk("add_lat_e2", 64'(alu_result), 64'd0);

    // Back-to-back SUB then SRAI
    drive(7'b0110011, 3'b000, 1'b1, 32'd3, 32'd5, 32'd0, 32'h80, 4'd4);
    push(4'd4, 32'hFFFF_FFFE, 1'b0, 32'h84);
    cyc();
    drive(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'h84, 4'd5);
    push(4'd5, 32'hF800_0000, 1'b0, 32'h88);
    cyc();
    alu_en = 1'b0;
    chk("b2b_pulse1", 64'(alu_result), 64'd1);
    cyc();
    chk("b2b_pulse2", 64'(alu_result), 64'd1);
    cyc();
    chk("b2b_idle", 64'(alu_result), 64'd0);

    // Branches, jumps and boundaries
    one(7'b1100011, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8, 32'h100, 4'd6,
        32'd0, 1'b1, 32'hF8);
    one(7'b1100011, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8, 32'h100, 4'd7,
        32'd0, 1'b0, 32'h104);
    one(7'b1100111, 3'b000, 1'b0, 32'h1003, 32'd0, 32'd2, 32'h200, 4'd8,
        32'h204, 1'b1, 32'h1004);
    one(7'b1101111, 3'b000, 1'b0, 32'd0, 32'd0, 32'd8, 32'hFFFF_FFFC, 4'd9,
        32'd0, 1'b1, 32'd4);
    one(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFC, 4'd10,
        32'd2, 1'b0, 32'd0);
    one(7'b0110011, 3'b101, 1'b1, 32'h8000_0000, 32'd31, 32'd0, 32'h10, 4'd11,
        32'hFFFF_FFFF, 1'b0, 32'h14);
    one(7'b0110011, 3'b001, 1'b0, 32'h1234, 32'h20, 32'd0, 32'h20, 4'd12,
        32'h1234, 1'b0, 32'h24);
    one(7'b0110111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'h30, 4'd13,
        32'h1234_5000, 1'b0, 32'h34);
    one(7'b0010111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h0000_1000, 32'h30, 4'd14,
        32'h1030, 1'b0, 32'h34);
    one(7'b0000000, 3'b000, 1'b0, 32'd9, 32'd9, 32'd9, 32'h50, 4'd15,
        32'd0, 1'b0, 32'h54);

    // Rollback drops both the in-flight op and the one dispatched with it
    drive(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 32'h60, 4'd1);
    cyc();
    drive(7'b0110011, 3'b000, 1'b0, 32'd3, 32'd4, 32'd0, 32'h64, 4'd2);
    rollback = 1'b1;
    cyc();
    rollback = 1'b0;
    chk("rb_e1", 64'(alu_result), 64'd0);
    drive(7'b0110011, 3'b100, 1'b0, 32'hF0, 32'h0F, 32'd0, 32'h68, 4'd3);
    push(4'd3, 32'hFF, 1'b0, 32'h6C);
    cyc();
    alu_en = 1'b0;
    chk("rb_e2", 64'(alu_result), 64'd0);
    cyc();
    chk("rb_e3", 64'(alu_result), 64'd1);
    cyc();

    // rdy low freezes the pipeline
    drive(7'b0110011, 3'b111, 1'b0, 32'hFF00, 32'h0FF0, 32'd0, 32'h70, 4'd5);
    push(4'd5, 32'h0F00, 1'b0, 32'h74);
    cyc();
    alu_en = 1'b0;
    rdy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("rdy_hold", 64'(alu_result), 64'd0);
    end
    rdy = 1'b1;
    cyc();
    chk("rdy_resume", 64'(alu_result), 64'd1);
    cyc();
    chk("rdy_after", 64'(alu_result), 64'd0);

    // Reset while a pulse is on the outputs
    drive(7'b0110011, 3'b110, 1'b0, 32'h5, 32'hA, 32'd0, 32'h90, 4'd6);
    push(4'd6, 32'hF, 1'b0, 32'h94);
    cyc();
    alu_en = 1'b0;
    cyc();
    chk("mid_pulse", 64'(alu_result), 64'd1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_result", 64'(alu_result), 64'd0);
    chk("mid_rst_val", 64'(alu_result_val), 64'd0);
    rst = 1'b0;
    cyc();

    // Back-to-back stream of mixed ops checked against the model
    for (int i = 0; i < 32; i++) begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] v1, v2, imm, pc;
      int          sel;
      sel = $urandom_range(0, 2);
      op  = (sel == 0) ? 7'b0110011 : (sel == 1) ? 7'b0010011 : 7'b1100011;
      f3  = 3'($urandom_range(0, 7));
      f7  = 1'($urandom_range(0, 1));
      v1  = $urandom;
      v2  = (i % 4 == 0) ? v1 : $urandom;
      imm = {{20{1'b0}}, 12'($urandom)};
      if (imm[11]) imm[31:12] = 20'hFFFFF;
      pc  = $urandom & 32'hFFFF_FFFC;
      drive(op, f3, f7, v1, v2, imm, pc, 4'(i));
      sb_q.push_back(model(op, f3, f7, v1, v2, imm, pc, 4'(i)));
      cyc();
    end
    alu_en = 1'b0;
    for (int i = 0; i < 4; i++) cyc();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
